// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory responder: 256 x 32-bit word storage behind a
// valid/ready request channel and a valid/ready response channel. A request is
// captured in IDLE, performed in ACCESS, and its response is held in RESP until
// the initiator takes it.
//
// Configuration macro:
//   DMEM_RANGE_CHECK_EN  when defined, any address with req_addr[31:10] != 0 is
//                        rejected with rsp_err=1. When undefined, the upper
//                        address bits are ignored and the access wraps onto
//                        req_addr[9:2]. Misaligned addresses are rejected in
//                        both builds.
//
// Ports:
//   clk        in   1   core clock
//   rst        in   1   synchronous active-high reset
//   req_valid  in   1   initiator presents a request
//   req_ready  out  1   responder accepts a request this cycle (IDLE only)
//   req_we     in   1   1 = store, 0 = load
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data
//   req_be     in   4   byte enables, bit i covers bits 8i+7:8i
//   rsp_valid  out  1   response available (RESP only)
//   rsp_ready  in   1   initiator accepts the response
//   rsp_rdata  out  32  load data; 0 for stores and error responses
//   rsp_err    out  1   request rejected, no memory side effect
// -----------------------------------------------------------------------------
module dmem_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e      state_q, state_d;

    // Captured request
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    // Response register
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [256];

    logic        accept;
    logic        do_access;
    logic        misaligned;
    logic        range_err;
    logic        access_err;
    logic [7:0]  word_idx;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge values of the others; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. Keeping req_ready low in RESP means a request can never be
    // taken in the same cycle as a response handshake.
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
    end

    assign accept    = req_valid && req_ready;
    assign do_access = (state_q == ACCESS);
    assign word_idx  = addr_q[9:2];

    // -------------------------------------------------------------------------
    // Error classification of the captured request
    // -------------------------------------------------------------------------
    assign misaligned = (addr_q[1:0] != 2'b00);

`ifdef DMEM_RANGE_CHECK_EN
    assign range_err = (addr_q[31:10] != 22'd0);
`else
    // Upper bits are deliberately ignored: the access wraps onto addr_q[9:2].
    logic unused_upper_addr;
    assign unused_upper_addr = ^addr_q[31:10];
    assign range_err         = 1'b0;
`endif

    assign access_err = misaligned || range_err;

    // -------------------------------------------------------------------------
    // Request capture; inputs are only looked at on an IDLE handshake.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // -------------------------------------------------------------------------
    // Response register: loaded once in ACCESS, then held through RESP.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (do_access) begin
            rsp_err_q   <= access_err;
            rsp_rdata_q <= (!we_q && !access_err) ? mem[word_idx] : 32'd0;
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // -------------------------------------------------------------------------
    // Storage. The rst term blocks a store whose ACCESS edge coincides with
    // reset; an all-zero byte enable simply writes nothing.
    // -------------------------------------------------------------------------
    // NOTE: the memory array has no reset so it maps onto RAM; resetting 256
    // words would force it into discrete flops.
    always_ff @(posedge clk) begin
        if (!rst && do_access && we_q && !access_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. A word-array reference model applies
// the load/store/error rules directly; every response, the handshake timing and
// the hold behaviour are compared against it. Inputs are driven and outputs
// sampled on the falling edge, away from the active rising edge.
// Compile with +define+DMEM_RANGE_CHECK_EN to match a range-checking build.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem [256];

`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Junk on the request channel while the responder is busy; it must be ignored.
    task automatic drive_garbage();
        req_valid = 1'($urandom);
        req_we    = 1'b1;
        req_addr  = {22'd0, 8'($urandom), 2'b00};
        req_wdata = $urandom;
        req_be    = 4'hF;
    endtask

    // One complete transaction, entered and left at a falling edge so the next
    // call can be accepted at the very next rising edge (3-cycle spacing).
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold);
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] word;
        int          idx;

        idx       = int'(addr[9:2]);
        exp_err   = (addr % 4 != 0) || (RANGE_CHECK && (addr / 1024 != 0));
        exp_rdata = (!we && !exp_err) ? ref_mem[idx] : 32'd0;
        if (we && !exp_err) begin
            word = ref_mem[idx];
            for (int b = 0; b < 4; b++)
                if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[idx] = word;
        end

        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = 1'b0;

        @(negedge clk);  // accept edge T passed: ACCESS
        drive_garbage();
        check("access_rsp_valid", 32'(rsp_valid), 32'd0);
        check("access_req_ready", 32'(req_ready), 32'd0);

        @(negedge clk);  // edge T+1 passed: RESP
        check("rsp_valid_lat2", 32'(rsp_valid), 32'd1);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));

        for (int i = 0; i < hold; i++) begin
            drive_garbage();
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_rdata", rsp_rdata, exp_rdata);
            check("hold_rsp_err", 32'(rsp_err), 32'(exp_err));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end

        // Handshake cycle with a live request on the input: it must not be taken.
        rsp_ready = 1'b1;
        drive_garbage();
        req_valid = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("post_rsp_req_ready", 32'(req_ready), 32'd1);
        check("post_rsp_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Give every word a known value so later loads are fully predictable.
        for (int i = 0; i < 256; i++)
            do_req(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

        // Full-word store then load, back to back.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
        check("dir_raw_word", ref_mem[4], 32'hDEADBEEF);

        // Single-byte store merges into the existing word.
        do_req(1'b1, 32'h10, 32'h0000AA00, 4'b0010, 0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
        check("dir_byte_merge", ref_mem[4], 32'hDEADAAEF);

        // Response held 5 cycles with request pulses that must be ignored.
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 5);

        // Misaligned load and store; 0x10 must stay untouched.
        do_req(1'b0, 32'h13, 32'h0, 4'h0, 0);
        do_req(1'b1, 32'h12, 32'h12345678, 4'hF, 1);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);

        // Zero byte-enable store leaves memory unchanged.
        do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);

        // Out-of-range address: error or wrap depending on the build.
        do_req(1'b1, 32'h0, 32'h11111111, 4'hF, 0);
        do_req(1'b0, 32'h400, 32'h0, 4'h0, 0);

        // Reset in ACCESS of a store: no response, no write.
        do_req(1'b1, 32'h20, 32'h5, 4'hF, 0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        @(negedge clk);  // accepted, now in ACCESS
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);  // ACCESS edge coincided with reset
        rst = 1'b0;
        check("rst_abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_abort_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("rst_abort_no_rsp", 32'(rsp_valid), 32'd0);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 0);

        // Randomized mix: mostly aligned in-range, some misaligned, some high.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int          kind;
            kind = $urandom_range(0, 9);
            a    = {22'd0, 8'($urandom), 2'b00};
            if (kind == 8) a[1:0] = 2'($urandom_range(1, 3));
            if (kind == 9) a[31:10] = 22'($urandom_range(1, 4194303));
            do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst; every flop samples on posedge clk, and rst is sampled only at that edge.
REQ-002 clk  input  1  core clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req_valid  input  1  initiator presents a request.
REQ-005 req_ready  output  1  responder can accept a request this cycle.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data.
REQ-009 req_be  input  4  byte enables; bit i covers byte i (bits 8i+7:8i).
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator accepts the response.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and error responses.
REQ-013 rsp_err  output  1  request rejected; no memory side effect.

Function
REQ-014 Storage SHALL be 256 x 32-bit words, indexed by req_addr[9:2]; contents are not reset.
REQ-015 FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-017 In IDLE, when req_valid and req_ready are both 1, the block SHALL capture we, addr, wdata and be, and go to ACCESS.
REQ-018 In ACCESS, a valid store SHALL write only the enabled bytes; a valid load SHALL read the full word into the response register; the state SHALL then go to RESP.
REQ-019 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready is 1; the state SHALL then return to IDLE.
REQ-020 Latency SHALL be: request accepted at edge T, rsp_valid high from T+2; minimum spacing between accepted requests is 3 cycles.
REQ-021 A new request SHALL NOT be accepted in the same cycle as a response handshake.
REQ-022 A request with req_addr[1:0] != 0 SHALL be misaligned: rsp_err=1, no write, rsp_rdata=0.
REQ-023 A store with req_be=4'b0000 SHALL complete with rsp_err=0 and leave memory unchanged.
REQ-024 Loads SHALL return the word as it was after every previously completed store (read-after-write ordering).
REQ-025 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-026 With rst=1 at a clock edge: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and captured request registers=0.
REQ-027 Reset during ACCESS or RESP SHALL abort the transaction with no response; a store whose ACCESS edge coincides with rst=1 SHALL NOT write.

Configuration
REQ-028 Macro DMEM_RANGE_CHECK_EN SHALL select out-of-range handling.
- Defined: req_addr[31:10] != 0 gives rsp_err=1, no write, rsp_rdata=0.
- Undefined: upper address bits are ignored; the access wraps onto req_addr[9:2].
- Misalignment checking (REQ-022) SHALL apply in both builds.

Verification
REQ-029 Store addr=0x10, wdata=0xDEADBEEF, be=4'hF, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid exactly 2 cycles after each accept.
REQ-030 Store 0x10 be=4'b0010, wdata=0x0000AA00, then load 0x10 -> 0xDEADAAEF.
REQ-031 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, a req_valid pulse is ignored; after rsp_ready=1, req_ready=1 on the next cycle.
REQ-032 Load 0x13 -> rsp_err=1, rsp_rdata=0; store 0x12 -> rsp_err=1 and a following load of 0x10 is unchanged.
REQ-033 Load 0x400 after storing 0x11111111 at 0x0 -> with DMEM_RANGE_CHECK_EN: rsp_err=1, rsp_rdata=0; without it: rsp_rdata=0x11111111, rsp_err=0.
REQ-034 Assert rst in ACCESS of a store to 0x20 (prior value 0x5) -> no rsp_valid, req_ready=1 the cycle after reset, and a later load of 0x20 returns 0x5.
